// File: rtl/pd_multi_if.sv
// pd_multi_if: serial stream, pattern configuration and detect results of pd_multi.
interface pd_multi_if #(
   parameter int SEQ_LEN = 8,
   parameter int NUM_PAT = 4,
   parameter int CNT_W   = 16
);
   localparam int ID_W = NUM_PAT > 1 ? $clog2(NUM_PAT) : 1;
   logic                       x_i;
   logic                       valid_i;
   logic                       clear_i;
   logic                       overlap_i;
   logic [NUM_PAT*SEQ_LEN-1:0] pat_i;
   logic [NUM_PAT*SEQ_LEN-1:0] mask_i;
   logic [NUM_PAT-1:0]         en_i;
   logic [NUM_PAT-1:0]         hit_o;
   logic                       det_o;
   logic [ID_W-1:0]            hit_id_o;
   logic [CNT_W-1:0]           cnt_o;
   modport master (
      output x_i, valid_i, clear_i, overlap_i, pat_i, mask_i, en_i,
      input  hit_o, det_o, hit_id_o, cnt_o
   );
   modport slave (
      input  x_i, valid_i, clear_i, overlap_i, pat_i, mask_i, en_i,
      output hit_o, det_o, hit_id_o, cnt_o
   );
endinterface

// File: rtl/pd_multi.sv
// pd_multi: sliding-window serial detector against NUM_PAT masked runtime patterns.
// Define PD_MATCH_CNT_EN to build the saturating match counter; otherwise cnt_o is 0.
module pd_multi #(
   parameter int SEQ_LEN = 8,
   parameter int NUM_PAT = 4,
   parameter int CNT_W   = 16
) (
   input logic       clk,
   input logic       reset,
   pd_multi_if.slave bus
);
   localparam int ID_W = NUM_PAT > 1 ? $clog2(NUM_PAT) : 1;
   localparam int FW   = $clog2(SEQ_LEN);
   logic [SEQ_LEN-1:0] sr, w;
   logic [FW-1:0]      fill;
   logic               full;
   logic [NUM_PAT-1:0] match, hit;
   logic [ID_W-1:0]    id, hit_id;
   logic               det;
   assign w    = {sr[SEQ_LEN-2:0], bus.x_i};
   assign full = fill == FW'(SEQ_LEN-1);
   always_comb begin
      match = '0;
      for (int k = 0; k < NUM_PAT; k++)
         match[k] = bus.valid_i && full && bus.en_i[k] &&
                    (((w ^ bus.pat_i[k*SEQ_LEN +: SEQ_LEN]) & bus.mask_i[k*SEQ_LEN +: SEQ_LEN]) == '0);
   end
   always_comb begin
      id = '0;
      for (int k = NUM_PAT - 1; k >= 0; k--)
         if (match[k]) id = ID_W'(k);
   end
   // a non-overlapping hit restarts the fill so the next detect needs a fresh window
   always_ff @(posedge clk) begin
      if (reset || bus.clear_i) begin
         sr     <= '0;
         fill   <= '0;
         hit    <= '0;
         det    <= 1'b0;
         hit_id <= '0;
      end else begin
         hit    <= match;
         det    <= |match;
         hit_id <= id;
         if (bus.valid_i) begin
            sr   <= w;
            fill <= (|match && !bus.overlap_i) ? '0 : full ? fill : fill + 1'b1;
         end
      end
   end
   assign bus.hit_o    = hit;
   assign bus.det_o    = det;
   assign bus.hit_id_o = hit_id;
`ifdef PD_MATCH_CNT_EN
   logic [CNT_W-1:0] cnt;
   always_ff @(posedge clk) begin
      if (reset || bus.clear_i) cnt <= '0;
      else if (|match && cnt != '1) cnt <= cnt + 1'b1;
   end
   assign bus.cnt_o = cnt;
`else
   assign bus.cnt_o = '0;
`endif
endmodule

// File: tb/tb_pd_multi.sv
// tb_pd_multi: table-driven directed vectors for pd_multi, plus a counter saturation sequence.
module tb_pd_multi;
   localparam int SL = 8;
   localparam int NP = 4;
`ifdef PD_MATCH_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif
   typedef struct {
      logic       x;
      logic       v;
      logic       cl;
      logic       rs;
      logic [3:0] eh;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   exp_cnt = 0;
   vec_t tbl[$];

   pd_multi_if #(.SEQ_LEN(SL), .NUM_PAT(NP), .CNT_W(16)) bus ();
   pd_multi_if #(.SEQ_LEN(SL), .NUM_PAT(NP), .CNT_W(2))  sbus ();

   pd_multi #(.SEQ_LEN(SL), .NUM_PAT(NP), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));
   pd_multi #(.SEQ_LEN(SL), .NUM_PAT(NP), .CNT_W(2))  dut_s (.clk(clk), .reset(reset), .bus(sbus));

   always #5 clk = ~clk;

   task automatic chk(input string name, input int row, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
      end
   endtask

   function automatic int low_id(input logic [3:0] h);
      int r = 0;
      for (int k = NP - 1; k >= 0; k--)
         if (h[k]) r = k;
      return r;
   endfunction

   task automatic cfg(input int k, input logic [SL-1:0] p, input logic [SL-1:0] m);
      bus.pat_i[k*SL +: SL]  = p;
      bus.mask_i[k*SL +: SL] = m;
   endtask

   task automatic add(input logic x, input logic v, input logic cl, input logic rs, input logic [3:0] eh);
      tbl.push_back('{x, v, cl, rs, eh});
   endtask

   // bits sent MSB first; det_at[i] marks the i-th sent bit (0-based) as completing a match
   task automatic add_bits(input logic [15:0] bits, input int n, input logic [15:0] det_at, input logic [3:0] h);
      for (int i = 0; i < n; i++)
         add(bits[n-1-i], 1'b1, 1'b0, 1'b0, det_at[i] ? h : 4'b0);
   endtask

   task automatic run(input string name);
      foreach (tbl[i]) begin
         bus.x_i     = tbl[i].x;
         bus.valid_i = tbl[i].v;
         bus.clear_i = tbl[i].cl;
         reset       = tbl[i].rs;
         @(posedge clk);
         #1;
         if (tbl[i].cl || tbl[i].rs) exp_cnt = 0;
         else if (tbl[i].eh != 4'b0 && exp_cnt < 65535) exp_cnt++;
         chk({name, ".hit"}, i, int'(bus.hit_o), int'(tbl[i].eh));
         chk({name, ".det"}, i, int'(bus.det_o), int'(|tbl[i].eh));
         chk({name, ".id"}, i, int'(bus.hit_id_o), low_id(tbl[i].eh));
         chk({name, ".cnt"}, i, int'(bus.cnt_o), CNT_EN ? exp_cnt : 0);
      end
      tbl.delete();
      bus.valid_i = 1'b0;
      bus.clear_i = 1'b0;
      reset       = 1'b0;
   endtask

   initial begin
      bus.x_i = 1'b0;  bus.valid_i = 1'b0;  bus.clear_i = 1'b0;  bus.overlap_i = 1'b1;
      bus.pat_i = '0;  bus.mask_i = '0;  bus.en_i = '0;
      sbus.x_i = 1'b0; sbus.valid_i = 1'b0; sbus.clear_i = 1'b0; sbus.overlap_i = 1'b1;
      sbus.pat_i = '0; sbus.mask_i = '0; sbus.en_i = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.hit", 0, int'(bus.hit_o), 0);
      chk("rst.det", 0, int'(bus.det_o), 0);
      chk("rst.id", 0, int'(bus.hit_id_o), 0);
      chk("rst.cnt", 0, int'(bus.cnt_o), 0);
      chk("rst.scnt", 0, int'(sbus.cnt_o), 0);
      reset = 1'b0;

      cfg(0, 8'hAC, 8'hFF);
      bus.en_i = 4'b0001;
      add_bits(16'hAC, 8, 16'h0080, 4'b0001);
      run("basic");

      cfg(0, 8'hAA, 8'hFF);
      add(1'b1, 1'b1, 1'b1, 1'b0, 4'b0);
      add_bits(16'hAAAA, 16, 16'hAA80, 4'b0001);
      run("ovl");

      bus.overlap_i = 1'b0;
      add(1'b1, 1'b1, 1'b1, 1'b0, 4'b0);
      add_bits(16'hAAAA, 16, 16'h8080, 4'b0001);
      run("novl");

      bus.overlap_i = 1'b1;
      cfg(1, 8'hA0, 8'hF0);
      cfg(3, 8'hAC, 8'hFF);
      bus.en_i = 4'b1010;
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0);
      add_bits(16'hAC, 8, 16'h0080, 4'b1010);
      run("mask");

      cfg(0, 8'hAC, 8'hFF);
      bus.en_i = 4'b0001;
      add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0);
      add_bits(16'hA, 4, 16'h0, 4'b0);
      for (int i = 0; i < 3; i++) add(i[0], 1'b0, 1'b0, 1'b0, 4'b0);
      add_bits(16'hC, 4, 16'h0008, 4'b0001);
      run("gap");

      add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0);
      add_bits(16'h15, 5, 16'h0, 4'b0);
      add(1'b1, 1'b1, 1'b1, 1'b0, 4'b0);
      add_bits(16'h4, 3, 16'h0, 4'b0);
      add_bits(16'hAC, 8, 16'h0080, 4'b0001);
      run("clr");

      add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0);
      add_bits(16'h15, 5, 16'h0, 4'b0);
      add(1'b1, 1'b1, 1'b0, 1'b1, 4'b0);
      add_bits(16'h4, 3, 16'h0, 4'b0);
      add_bits(16'hAC, 8, 16'h0080, 4'b0001);
      run("rstmid");

      sbus.en_i = 4'b0001;
      for (int i = 0; i < 12; i++) begin
         sbus.x_i     = i[0];
         sbus.valid_i = 1'b1;
         @(posedge clk);
         #1;
         chk("sat.det", i, int'(sbus.det_o), int'(i >= 7));
         chk("sat.cnt", i, int'(sbus.cnt_o), CNT_EN ? ((i < 7) ? 0 : (i - 6 > 3) ? 3 : i - 6) : 0);
      end
      sbus.valid_i = 1'b0;
      @(posedge clk);
      #1;
      chk("sat.idle_det", 12, int'(sbus.det_o), 0);
      chk("sat.hold", 12, int'(sbus.cnt_o), CNT_EN ? 3 : 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pd_multi.md
# pd_multi

Parametrised multi-pattern serial detector, successor to the single-pattern 8-bit detector. It sits on a 1-bit serial stream qualified by `valid_i` and compares a sliding `SEQ_LEN`-bit window against up to `NUM_PAT` runtime-programmable patterns, each with its own don't-care mask. It selects overlapping or non-overlapping detection at runtime. It reports per-pattern hit pulses, a combined detect pulse and the lowest matching pattern index, plus an optional saturating match counter.

## Interface
- `SEQ_LEN`, 8: window length in bits, ≥2.
- `NUM_PAT`, 4: number of pattern slots, ≥1.
- `CNT_W`, 16: match counter width.
- `clk`  in  1  clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `x_i`  in  1  serial data bit; the newest bit becomes window LSB.
- `valid_i`  in  1  `x_i` is consumed only when high.
- `clear_i`  in  1  synchronous flush of window, fill state, hits and counter.
- `overlap_i`  in  1  1 = overlapping detection, 0 = non-overlapping.
- `pat_i`  in  NUM_PAT*SEQ_LEN  pattern k is at `[k*SEQ_LEN +: SEQ_LEN]`, MSB = oldest bit.
- `mask_i`  in  NUM_PAT*SEQ_LEN  per-bit compare enable (1 = compare, 0 = don't care), same packing as `pat_i`.
- `en_i`  in  NUM_PAT  per-slot enable.
- `hit_o`  out  NUM_PAT  registered per-slot match pulse.
- `det_o`  out  1  registered OR of `hit_o`.
- `hit_id_o`  out  max(1,$clog2(NUM_PAT))  lowest index with a hit; 0 when `det_o`=0.
- `cnt_o`  out  CNT_W  match event count (see Configuration).

## Operation
- State:
  - shift register `sr[SEQ_LEN-1:0]`.
  - fill counter `fill`, 0..SEQ_LEN-1, saturating; it counts bits accepted since reset, clear or a non-overlap restart.
  - output registers.
- On a cycle with `valid_i`=1:
  - Candidate window w = {sr[SEQ_LEN-2:0], x_i}.
  - `sr` ← w.
  - `fill` ← min(fill+1, SEQ_LEN-1).
- Window full: the window is full when `fill` == SEQ_LEN-1 at the sampling edge, so the current bit completes SEQ_LEN valid bits.
- Slot k matches when all of the following hold:
  - `valid_i`=1.
  - The window is full.
  - `en_i[k]`=1.
  - ((w ^ pat_k) & mask_k) == 0.
- `hit_o[k]` ← match_k. `det_o` ← |match. `hit_id_o` ← the lowest k with match_k.
- On a cycle with `valid_i`=0:
  - `sr` and `fill` hold.
  - `hit_o`, `det_o` and `hit_id_o` ← 0, so each output is a one-cycle pulse per accepted bit.
- Overlap behaviour when a match occurs:
  - `overlap_i`=1: `fill` is unaffected.
  - `overlap_i`=0: `fill` ← 0. `sr` still loads w, but a further detection needs SEQ_LEN fresh bits.
- All-zero mask on an enabled slot: the slot matches on every accepted bit once the window is full (legal).
- `pat_i`, `mask_i`, `en_i` and `overlap_i` are sampled only on the valid cycle. Changes take effect on the next accepted bit; no staging is required.
- Clear and reset:
  - `clear_i`=1: `sr`, `fill`, all outputs and the counter ← 0. This takes priority over `valid_i`; the bit that cycle is dropped.
  - `reset` has the same effect as `clear_i` and priority over everything.

## Timing
- Reset values: `sr`=0, `fill`=0, `hit_o`=0, `det_o`=0, `hit_id_o`=0, `cnt_o`=0.
- Latency: a bit accepted at edge N produces `det_o` high from edge N to edge N+1, i.e. visible in the cycle after `x_i` is presented.
- First possible detect: on the SEQ_LEN-th accepted bit after reset or clear. Zeros from reset never alias a pattern.
- Reset or clear asserted mid-stream: outputs are 0 the following cycle, and any partial window is discarded.
- Simultaneous multi-slot match:
  - All matching `hit_o` bits are set.
  - `hit_id_o` = lowest index.
  - The counter increments by 1, not by the number of hits.

## Configuration
- `PD_MATCH_CNT_EN` defined:
  - `cnt_o` increments by 1 on each accepted bit with |match.
  - It saturates at 2^CNT_W-1.
  - It clears on `reset` or `clear_i`.
- Undefined: the counter logic is absent and `cnt_o` is tied to 0. The port list is unchanged.

## Test plan
- Basic match:
  - Setup: SEQ_LEN=8; slot0 pat=8'hAC, mask=8'hFF, en=4'b0001, overlap=1.
  - Stimulus: feed 1,0,1,0,1,1,0,0.
  - Required: `det_o`=1, `hit_o`=4'b0001 and `hit_id_o`=0 exactly one cycle after the 8th bit; 0 otherwise.
- Overlap vs non-overlap:
  - Setup: slot0 pat=8'hAA, mask=8'hFF.
  - Stimulus: feed 16 bits alternating 1,0,…
  - Required with overlap=1: detects after bits 8, 10, 12, 14 and 16.
  - Required with overlap=0: detects after bits 8 and 16 only.
- Masks and priority:
  - Setup: slot1 pat=8'hA0, mask=8'hF0; slot3 pat=8'hAC, mask=8'hFF; en=4'b1010.
  - Stimulus: feed 8'hAC.
  - Required: `hit_o`=4'b1010, `hit_id_o`=1, and the counter +1 (with `PD_MATCH_CNT_EN`).
- Valid gaps:
  - Stimulus: feed 8'hAC with `valid_i` low for 3 cycles between bits 4 and 5.
  - Required: single detect after the 8th accepted bit; no pulses during the gaps.
- Clear/reset mid-stream:
  - Stimulus: feed 5 bits of 8'hAC, pulse `clear_i`, then feed 3 remaining bits.
  - Required: no detect.
  - Follow-up: feed the full 8'hAC → detect.
  - Also repeat using `reset`.
- Counter saturation:
  - Setup: CNT_W=2, all-zero mask on slot0, overlap=1.
  - Stimulus: feed 12 bits.
  - Required: `cnt_o` reaches 3 and holds.
  - Without the macro: `cnt_o` stays 0.
